dmux4_dispatch_ctrl: RTL and testbench
======================================

Name: dmux4_dispatch_ctrl

Overview:
Sequencing controller for the 8-bit 1-to-4 demultiplexer datapath. Accepts a byte stream on a valid/ready input. Picks a destination channel, either round-robin or addressed, and drives the demux select. Captures each routed byte in a one-entry holding register per channel, presented on an independent valid/ready output. Sits between a single byte producer and four byte consumers (W, X, Y, Z).

Parameters:
CNT_W, 16, width of the dispatched-byte counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  1 = run; 0 = stop accepting and drain
rr_mode  input  1  1 = round-robin destination, 0 = addressed by in_dest
in_data  input  8  byte to dispatch
in_dest  input  2  destination channel in addressed mode (0=W,1=X,2=Y,3=Z)
in_valid  input  1  in_data/in_dest valid
in_ready  output  1  controller accepts the byte this cycle
sel  output  2  demux select for the current target channel (combinational)
out_w, out_x, out_y, out_z  output  8 each  channel holding registers
out_valid  output  4  bit i = channel i holds a byte
out_ready  input  4  bit i = consumer i takes the byte this cycle
rr_ptr  output  2  next round-robin channel
state  output  2  00 IDLE, 01 RUN, 10 DRAIN
dispatched  output  CNT_W  total accepted bytes

Behaviour:
- Reset (rst=1 at clk edge) values: state=IDLE, rr_ptr=0, out_valid=0, out_w/x/y/z=8'h00, dispatched=0. rst has priority over everything.
- target = rr_ptr if rr_mode=1, else in_dest. sel = target at all times.
- slot_free[i] = ~out_valid[i] | out_ready[i]. A full channel being drained this cycle can accept in the same cycle.
- in_ready = (state==RUN) & slot_free[target]. It is combinational and must not depend on in_valid.
- Accept = in_valid & in_ready.
- On accept:
  - out_<target> <= in_data.
  - out_valid[target] <= 1.
  - dispatched <= dispatched+1.
  - If rr_mode=1, rr_ptr <= rr_ptr+1 (3 wraps to 0).
- Latency: one cycle from accept to out_valid. Throughput: one byte per cycle if the target slot is free.
- Output handshake, channel i:
  - out_valid[i] & out_ready[i] with no new accept to i clears out_valid[i]. Data register is held (not cleared).
  - out_valid[i] stays high, with data stable, until taken.
- Round-robin is strict in-order: if channel rr_ptr is full and not draining, input stalls. It does not skip to a free channel. rr_ptr changes only on an accept in rr_mode.
- Addressed mode does not touch rr_ptr.
- Changing rr_mode mid-stream takes effect the same cycle (target/sel follow rr_mode combinationally).
- FSM:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> DRAIN; the byte is still accepted in that same cycle if in_ready was 1.
  - DRAIN: in_ready=0. When out_valid==0 after this cycle's drains -> IDLE. enable=1 -> RUN (takes priority over the IDLE exit).
  - IDLE: in_ready=0; output handshakes still function.
- Output-side drains continue in all states.
- Reset mid-operation: held bytes are discarded (out_valid cleared), counter cleared, no partial transfer.
- dispatched wraps from 2^CNT_W-1 to 0 without flag.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with in_valid=1, then enable=0 -> out_valid=0000, in_ready=0, dispatched=0, state=IDLE.
- Round-robin burst:
  - Stimulus: enable=1, rr_mode=1, out_ready=1111; push 8'hA0..A7 back-to-back.
  - Required: bytes land W,X,Y,Z,W,X,Y,Z (A0 on out_w, A1 on out_x, ...), one per cycle; sel sequence 0,1,2,3,0,...; dispatched=8; rr_ptr=0.
- Strict RR stall:
  - Stimulus: rr_mode=1, out_ready=0000; push 5 bytes.
  - Required: the first 4 fill W..Z; the 5th stalls with in_ready=0, sel=0.
  - Then raise out_ready[0] for one cycle -> same-cycle accept into W, out_valid stays 1111.
- Addressed mode:
  - Stimulus: rr_mode=0; in_dest=2 with 8'h55, then in_dest=2 with 8'h66 while out_ready[2]=0.
  - Required: out_y=8'h55; second byte stalls until out_ready[2]=1, then out_y=8'h66; rr_ptr unchanged.
- Drain:
  - Stimulus: with out_valid=0110, drop enable.
  - Required: state=DRAIN, in_ready=0; after channels 1 and 2 are taken, state=IDLE next cycle.
  - Re-assert enable during DRAIN -> RUN directly.
- Reset mid-flight: assert rst while out_valid=1111 and in_valid=1 -> next cycle out_valid=0000, rr_ptr=0, no byte accepted.

Source files
------------

// File: rtl/dmux4_dispatch_ctrl.sv
// rtl/dmux4_dispatch_ctrl.sv - byte dispatcher driving a 1-to-4 demux with per-channel holding registers
module dmux4_dispatch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             rr_mode,
  input  logic [7:0]       in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       sel,
  output logic [7:0]       out_w,
  output logic [7:0]       out_x,
  output logic [7:0]       out_y,
  output logic [7:0]       out_z,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] dispatched
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t           r_state;
  logic [1:0]       r_rr_ptr;
  logic [3:0]       r_valid;
  logic [7:0]       r_data [4];
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_target;
  logic [3:0]       w_slot_free;
  logic [3:0]       w_take;
  logic [3:0]       w_load;
  logic [3:0]       w_valid_nxt;
  logic             w_accept;

  // Target follows rr_mode combinationally so a mode change applies this cycle
  assign w_target    = rr_mode ? r_rr_ptr : in_dest;
  assign sel         = w_target;

  // A slot being emptied this cycle can be refilled in the same cycle
  assign w_slot_free = ~r_valid | out_ready;
  assign in_ready    = (r_state == S_RUN) && w_slot_free[w_target];
  assign w_accept    = in_valid & in_ready;

  assign w_take      = r_valid & out_ready;
  assign w_load      = w_accept ? (4'b0001 << w_target) : 4'b0000;
  assign w_valid_nxt = (r_valid & ~w_take) | w_load;

  // Controller FSM; drain exits to idle only once every holding slot has emptied
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) r_state <= S_RUN;
        S_RUN:   if (!enable) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (enable) begin
            r_state <= S_RUN;
          end else if (w_valid_nxt == 4'b0000) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-channel valid flags, round-robin pointer and accepted-byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 4'b0000;
      r_rr_ptr <= 2'd0;
      r_cnt    <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (rr_mode) r_rr_ptr <= r_rr_ptr + 2'd1;
      end
    end
  end

  // Holding registers keep their last byte after it is taken; only a new accept overwrites
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_data[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) r_data[i] <= in_data;
      end
    end
  end

  assign out_w      = r_data[0];
  assign out_x      = r_data[1];
  assign out_y      = r_data[2];
  assign out_z      = r_data[3];
  assign out_valid  = r_valid;
  assign rr_ptr     = r_rr_ptr;
  assign state      = r_state;
  assign dispatched = r_cnt;

endmodule

// File: tb/tb_dmux4_dispatch_ctrl.sv
// tb/tb_dmux4_dispatch_ctrl.sv - scoreboard bench for dmux4_dispatch_ctrl
module tb_dmux4_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rr_mode;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [7:0]  out_w, out_x, out_y, out_z;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [1:0]  state;
  logic [15:0] dispatched;

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  exp_q [4][$];
  logic [15:0] exp_disp = 16'd0;
  logic [1:0]  exp_rr = 2'd0;

  dmux4_dispatch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rr_mode(rr_mode),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_w(out_w), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr),
    .state(state), .dispatched(dispatched)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] chan_data(input int i);
    case (i)
      0: return out_w;
      1: return out_x;
      2: return out_y;
      default: return out_z;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch, input logic [7:0] d);
    exp_q[ch].push_back(d);
    exp_disp = exp_disp + 16'd1;
  endtask

  // Consumer side: every byte handed over must be the next one expected on that channel
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          n_total++;
          if (exp_q[i].size() == 0) begin
            $display("FAIL sb_unexpected ch%0d got %02h expected no byte", i, chan_data(i));
          end else begin
            logic [7:0] e;
            e = exp_q[i].pop_front();
            if (chan_data(i) !== e) $display("FAIL sb_data ch%0d got %02h expected %02h", i, chan_data(i), e);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; rr_mode = 1'b1; in_data = 8'hEE; in_dest = 2'd0;
    in_valid = 1'b1; out_ready = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 4'b0000) $display("FAIL rst_out_valid got %b expected 0000", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b expected 0", in_ready); else n_pass++;
    n_total++; if (state !== 2'b00) $display("FAIL rst_state got %b expected 00", state); else n_pass++;
    n_total++; if (rr_ptr !== 2'd0) $display("FAIL rst_rr_ptr got %0d expected 0", rr_ptr); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (dispatched !== 16'd0) $display("FAIL idle_dispatched got %0d expected 0", dispatched); else n_pass++;
    n_total++; if (out_valid !== 4'b0000) $display("FAIL idle_out_valid got %b expected 0000", out_valid); else n_pass++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_rr_burst();
    enable = 1'b1; rr_mode = 1'b1; out_ready = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      in_data = 8'hA0 + 8'(k); in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (in_ready !== 1'b1) $display("FAIL rr_in_ready k=%0d got %b expected 1", k, in_ready); else n_pass++;
      n_total++; if (sel !== 2'(k % 4)) $display("FAIL rr_sel k=%0d got %0d expected %0d", k, sel, k % 4); else n_pass++;
      if (k > 0) begin
        n_total++;
        if (out_valid !== (4'b0001 << ((k - 1) % 4))) $display("FAIL rr_latency k=%0d got %b expected %b", k, out_valid, 4'b0001 << ((k - 1) % 4));
        else n_pass++;
      end
      push_exp(k % 4, 8'hA0 + 8'(k));
      exp_rr = exp_rr + 2'd1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 4'b1000) $display("FAIL rr_last_valid got %b expected 1000", out_valid); else n_pass++;
    n_total++; if (dispatched !== exp_disp) $display("FAIL rr_dispatched got %0d expected %0d", dispatched, exp_disp); else n_pass++;
    n_total++; if (rr_ptr !== exp_rr) $display("FAIL rr_ptr_end got %0d expected %0d", rr_ptr, exp_rr); else n_pass++;
    tick();
  endtask

  task automatic test_rr_stall();
    out_ready = 4'b0000; rr_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'hB0 + 8'(k); in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (in_ready !== 1'b1) $display("FAIL stall_fill_ready k=%0d got %b expected 1", k, in_ready); else n_pass++;
      push_exp(int'(exp_rr), in_data);
      exp_rr = exp_rr + 2'd1;
      tick();
    end
    in_data = 8'hB4;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b expected 0", in_ready); else n_pass++;
    n_total++; if (sel !== 2'd0) $display("FAIL stall_sel got %0d expected 0", sel); else n_pass++;
    n_total++; if (out_valid !== 4'b1111) $display("FAIL stall_full got %b expected 1111", out_valid); else n_pass++;
    tick();
    out_ready = 4'b0001;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL stall_same_cycle got %b expected 1", in_ready); else n_pass++;
    push_exp(int'(exp_rr), 8'hB4);
    exp_rr = exp_rr + 2'd1;
    tick();
    out_ready = 4'b0000; in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 4'b1111) $display("FAIL stall_refill got %b expected 1111", out_valid); else n_pass++;
    n_total++; if (rr_ptr !== exp_rr) $display("FAIL stall_rr_ptr got %0d expected %0d", rr_ptr, exp_rr); else n_pass++;
    tick();
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    @(negedge clk);
    n_total++; if (out_valid !== 4'b0000) $display("FAIL stall_drained got %b expected 0000", out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_addressed();
    rr_mode = 1'b0; out_ready = 4'b0000; in_dest = 2'd2; in_data = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL addr_ready got %b expected 1", in_ready); else n_pass++;
    n_total++; if (sel !== 2'd2) $display("FAIL addr_sel got %0d expected 2", sel); else n_pass++;
    push_exp(2, 8'h55);
    tick();
    in_data = 8'h66;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0) $display("FAIL addr_stall k=%0d got %b expected 0", k, in_ready); else n_pass++;
      n_total++; if (out_y !== 8'h55) $display("FAIL addr_hold got %02h expected 55", out_y); else n_pass++;
      tick();
    end
    out_ready = 4'b0100;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL addr_release got %b expected 1", in_ready); else n_pass++;
    push_exp(2, 8'h66);
    tick();
    out_ready = 4'b0000; in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_y !== 8'h66) $display("FAIL addr_second got %02h expected 66", out_y); else n_pass++;
    n_total++; if (out_valid !== 4'b0100) $display("FAIL addr_valid got %b expected 0100", out_valid); else n_pass++;
    n_total++; if (rr_ptr !== exp_rr) $display("FAIL addr_rr_ptr got %0d expected %0d", rr_ptr, exp_rr); else n_pass++;
    n_total++; if (dispatched !== exp_disp) $display("FAIL addr_dispatched got %0d expected %0d", dispatched, exp_disp); else n_pass++;
    tick();
  endtask

  task automatic test_drain();
    in_dest = 2'd1; in_data = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    push_exp(1, 8'h77);
    tick();
    in_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 4'b0110) $display("FAIL drain_pre_valid got %b expected 0110", out_valid); else n_pass++;
    tick();
    in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h99;
    @(negedge clk);
    n_total++; if (state !== 2'b10) $display("FAIL drain_state got %b expected 10", state); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL drain_ready got %b expected 0", in_ready); else n_pass++;
    tick();
    out_ready = 4'b0010;
    tick();
    @(negedge clk);
    n_total++; if (state !== 2'b10) $display("FAIL drain_partial got %b expected 10", state); else n_pass++;
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    @(negedge clk);
    n_total++; if (state !== 2'b00) $display("FAIL drain_idle got %b expected 00", state); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL idle_ready got %b expected 0", in_ready); else n_pass++;
    tick();
    enable = 1'b1; in_valid = 1'b0;
    tick();
    in_dest = 2'd0; in_data = 8'h88; in_valid = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL rerun_ready got %b expected 1", in_ready); else n_pass++;
    push_exp(0, 8'h88);
    tick();
    in_valid = 1'b0; enable = 1'b0;
    tick();
    @(negedge clk);
    n_total++; if (state !== 2'b10) $display("FAIL drain2_state got %b expected 10", state); else n_pass++;
    enable = 1'b1; out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    @(negedge clk);
    n_total++; if (state !== 2'b01) $display("FAIL drain_to_run got %b expected 01", state); else n_pass++;
    n_total++; if (out_valid !== 4'b0000) $display("FAIL drain_to_run_valid got %b expected 0000", out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midflight();
    rr_mode = 1'b1; out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'hC0 + 8'(k); in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (sel !== exp_rr) $display("FAIL mid_sel k=%0d got %0d expected %0d", k, sel, exp_rr); else n_pass++;
      push_exp(int'(exp_rr), in_data);
      exp_rr = exp_rr + 2'd1;
      tick();
    end
    @(negedge clk);
    n_total++; if (out_valid !== 4'b1111) $display("FAIL mid_full got %b expected 1111", out_valid); else n_pass++;
    tick();
    rst = 1'b1; out_ready = 4'b1111; in_data = 8'hC9; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    exp_disp = 16'd0; exp_rr = 2'd0;
    tick();
    rst = 1'b0; in_valid = 1'b0; enable = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    n_total++; if (out_valid !== 4'b0000) $display("FAIL mid_valid got %b expected 0000", out_valid); else n_pass++;
    n_total++; if (rr_ptr !== 2'd0) $display("FAIL mid_rr_ptr got %0d expected 0", rr_ptr); else n_pass++;
    n_total++; if (dispatched !== 16'd0) $display("FAIL mid_dispatched got %0d expected 0", dispatched); else n_pass++;
    n_total++; if (out_w !== 8'h00) $display("FAIL mid_out_w got %02h expected 00", out_w); else n_pass++;
    n_total++; if (state !== 2'b00) $display("FAIL mid_state got %b expected 00", state); else n_pass++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish got running expected done");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_burst();
    test_rr_stall();
    test_addressed();
    test_drain();
    test_reset_midflight();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (exp_q[i].size() != 0) $display("FAIL sb_leftover ch%0d got %0d pending expected 0", i, exp_q[i].size());
      else n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
